// File: rtl/pr_shutdown_axis_mc.sv
// Multi-channel packet-aware AXI-Stream decoupler for partial reconfiguration.
// Passes N streams combinationally and gates each one at a packet boundary on shutdown.
module pr_shutdown_axis_mc #(
  parameter int C_NUM_CHANNELS     = 2,
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int C_AXIS_TUSER_WIDTH = 1,
  parameter int C_AXIS_HAS_TLAST   = 1,
  parameter int C_TIMEOUT_CYCLES   = 1024,
  parameter int C_SINK_ON_SHUTDOWN = 1
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             shutdown_req,
  output logic                                             shutdown_ack,
  output logic                                             shutdown_timeout,
  input  logic [C_NUM_CHANNELS*C_AXIS_TDATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_NUM_CHANNELS*C_AXIS_TDATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic [C_NUM_CHANNELS*C_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic [C_NUM_CHANNELS-1:0]                        s_axis_tlast,
  input  logic [C_NUM_CHANNELS-1:0]                        s_axis_tvalid,
  output logic [C_NUM_CHANNELS-1:0]                        s_axis_tready,
  output logic [C_NUM_CHANNELS*C_AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_NUM_CHANNELS*C_AXIS_TDATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic [C_NUM_CHANNELS*C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic [C_NUM_CHANNELS-1:0]                        m_axis_tlast,
  output logic [C_NUM_CHANNELS-1:0]                        m_axis_tvalid,
  input  logic [C_NUM_CHANNELS-1:0]                        m_axis_tready
);

  localparam int N      = C_NUM_CHANNELS;
  localparam int TW_RAW = $clog2(C_TIMEOUT_CYCLES + 1);
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(C_TIMEOUT_CYCLES);
  localparam bit TIMER_EN = (C_TIMEOUT_CYCLES != 0);
  localparam bit SINK_EN  = (C_SINK_ON_SHUTDOWN != 0);
  localparam bit HAS_LAST = (C_AXIS_HAS_TLAST != 0);

  // OFF is the only encoding with bit 1 set, so the ack is a bare flop output.
  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_DRAIN = 2'b01;
  localparam logic [1:0] ST_OFF   = 2'b10;

  logic [1:0]    state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          timeout_q, timeout_nxt;
  logic [N-1:0]  pass_pkt, pass_upd, pass_d;
  logic [N-1:0]  sink_pkt, sink_upd, sink_d;
  logic [N-1:0]  open, sinking, tlast_eff, m_xfer, s_sink;
  logic          st_run, st_drain, st_off;

  assign st_run   = (state == ST_RUN);
  assign st_drain = (state == ST_DRAIN);
  assign st_off   = (state == ST_OFF);

  assign tlast_eff = HAS_LAST ? s_axis_tlast : '1;

  assign open    = {N{!rst}} & (({N{st_run}} & ~sink_pkt) | ({N{st_drain}} & pass_pkt));
  assign sinking = {N{SINK_EN && !rst}} & ({N{st_off}} | ({N{st_run}} & sink_pkt));

  // Data fields are never gated; only the handshake decides whether a beat moves.
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tuser  = s_axis_tuser;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tvalid = open & s_axis_tvalid;
  assign s_axis_tready = (open & m_axis_tready) | sinking;

  assign m_xfer = m_axis_tvalid & m_axis_tready;
  assign s_sink = sinking & s_axis_tvalid;

  // Packet-position tracking after this cycle's transfers.
  assign pass_upd = HAS_LAST ? ((pass_pkt & ~m_xfer) | (m_xfer & ~tlast_eff)) : '0;
  assign sink_upd = SINK_EN  ? ((sink_pkt & ~s_sink) | (s_sink & ~tlast_eff)) : '0;

  assign shutdown_ack     = state[1];
  assign shutdown_timeout = timeout_q;

  // NOTE: every output of this block is defaulted first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    timeout_nxt = timeout_q;
    pass_d      = pass_upd;
    sink_d      = sink_upd;
    case (state)
      ST_RUN: begin
        if (shutdown_req) begin
          state_nxt   = ST_DRAIN;
          timer_nxt   = TIMER_LOAD;
          timeout_nxt = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (!shutdown_req) begin
          state_nxt = ST_RUN;
        end else if (pass_upd == '0) begin
          state_nxt = ST_OFF;
        end else if (TIMER_EN && (timer == TW'(1))) begin
          // Forced close: unfinished packets are swallowed on the S side until their tlast.
          state_nxt   = ST_OFF;
          timeout_nxt = 1'b1;
          sink_d      = SINK_EN ? pass_upd : '0;
          pass_d      = '0;
        end else if (TIMER_EN) begin
          timer_nxt = timer - TW'(1);
        end
      end
      ST_OFF: begin
        if (!shutdown_req) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      timer     <= '0;
      timeout_q <= 1'b0;
      pass_pkt  <= '0;
      sink_pkt  <= '0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      timeout_q <= timeout_nxt;
      pass_pkt  <= pass_d;
      sink_pkt  <= sink_d;
    end
  end

endmodule

// File: tb/tb_pr_shutdown_axis_mc.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops on every M transfer.
// DUT a: sink mode with a 16-cycle drain timeout; DUT b: hold mode without timeout.
module tb_pr_shutdown_axis_mc;

  localparam int W  = 32;
  localparam int KW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req_a, ack_a, to_a;
  logic [2*W-1:0]  a_s_tdata, a_m_tdata;
  logic [2*KW-1:0] a_s_tkeep, a_m_tkeep;
  logic [1:0]      a_s_tuser, a_m_tuser, a_s_tlast, a_m_tlast;
  logic [1:0]      a_s_tvalid, a_s_tready, a_m_tvalid, a_m_tready;

  logic          req_b, ack_b, to_b;
  logic [2*W-1:0]  b_s_tdata, b_m_tdata;
  logic [2*KW-1:0] b_s_tkeep, b_m_tkeep;
  logic [1:0]      b_s_tuser, b_m_tuser, b_s_tlast, b_m_tlast;
  logic [1:0]      b_s_tvalid, b_s_tready, b_m_tvalid, b_m_tready;

  pr_shutdown_axis_mc #(
    .C_NUM_CHANNELS(2), .C_AXIS_TDATA_WIDTH(W), .C_AXIS_TUSER_WIDTH(1),
    .C_AXIS_HAS_TLAST(1), .C_TIMEOUT_CYCLES(16), .C_SINK_ON_SHUTDOWN(1)
  ) dut_a (
    .clk(clk), .rst(rst), .shutdown_req(req_a), .shutdown_ack(ack_a), .shutdown_timeout(to_a),
    .s_axis_tdata(a_s_tdata), .s_axis_tkeep(a_s_tkeep), .s_axis_tuser(a_s_tuser),
    .s_axis_tlast(a_s_tlast), .s_axis_tvalid(a_s_tvalid), .s_axis_tready(a_s_tready),
    .m_axis_tdata(a_m_tdata), .m_axis_tkeep(a_m_tkeep), .m_axis_tuser(a_m_tuser),
    .m_axis_tlast(a_m_tlast), .m_axis_tvalid(a_m_tvalid), .m_axis_tready(a_m_tready)
  );

  pr_shutdown_axis_mc #(
    .C_NUM_CHANNELS(2), .C_AXIS_TDATA_WIDTH(W), .C_AXIS_TUSER_WIDTH(1),
    .C_AXIS_HAS_TLAST(1), .C_TIMEOUT_CYCLES(0), .C_SINK_ON_SHUTDOWN(0)
  ) dut_b (
    .clk(clk), .rst(rst), .shutdown_req(req_b), .shutdown_ack(ack_b), .shutdown_timeout(to_b),
    .s_axis_tdata(b_s_tdata), .s_axis_tkeep(b_s_tkeep), .s_axis_tuser(b_s_tuser),
    .s_axis_tlast(b_s_tlast), .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready),
    .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep), .m_axis_tuser(b_m_tuser),
    .m_axis_tlast(b_m_tlast), .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected beat = {tuser, tkeep, tlast, tdata}; queues 0,1 = dut_a ch0/1, 2,3 = dut_b ch0/1.
  logic [37:0] exp_q [4][$];

  function automatic logic [37:0] mk(input logic [31:0] d, input logic l);
    return {d[0], d[7:4], l, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat on dut_a channel ch and waits (bounded) for its S-side handshake.
  task automatic drive_a(input int ch, input logic [31:0] d, input logic l, input bit pass);
    bit ok;
    a_s_tdata[ch*W +: W]   = d;
    a_s_tkeep[ch*KW +: KW] = d[7:4];
    a_s_tuser[ch]          = d[0];
    a_s_tlast[ch]          = l;
    a_s_tvalid[ch]         = 1'b1;
    if (pass) exp_q[ch].push_back(mk(d, l));
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      ok = a_s_tready[ch];
      tick();
      if (ok) break;
    end
    check("s handshake", 32'(ok), 32'd1);
    a_s_tvalid[ch] = 1'b0;
  endtask

  logic [37:0] mon_act, mon_exp;
  logic        mon_v;
  always @(negedge clk) begin
    for (int q = 0; q < 4; q++) begin
      if (q < 2) begin
        mon_v   = a_m_tvalid[q] & a_m_tready[q];
        mon_act = {a_m_tuser[q], a_m_tkeep[q*KW +: KW], a_m_tlast[q], a_m_tdata[q*W +: W]};
      end else begin
        mon_v   = b_m_tvalid[q-2] & b_m_tready[q-2];
        mon_act = {b_m_tuser[q-2], b_m_tkeep[(q-2)*KW +: KW], b_m_tlast[q-2], b_m_tdata[(q-2)*W +: W]};
      end
      if (mon_v) begin
        n_cmp++;
        if (exp_q[q].size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard q%0d: got beat %h expected none", q, mon_act);
        end else begin
          mon_exp = exp_q[q].pop_front();
          if (mon_act !== mon_exp) begin
            n_fail++;
            $display("FAIL scoreboard q%0d: got %h expected %h", q, mon_act, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_a = 1'b0; req_b = 1'b0;
    a_s_tdata = '0; a_s_tkeep = '0; a_s_tuser = '0; a_s_tlast = '0;
    b_s_tdata = '0; b_s_tkeep = '0; b_s_tuser = '0; b_s_tlast = '0;
    b_s_tvalid = '0;
    a_s_tvalid = 2'b11; a_m_tready = 2'b11; b_m_tready = 2'b11;

    // Reset: outputs forced idle even with traffic offered.
    tick(); tick();
    check("rst m_tvalid", 32'(a_m_tvalid), 32'h0);
    check("rst s_tready", 32'(a_s_tready), 32'h0);
    check("rst ack", 32'(ack_a), 32'h0);
    check("rst timeout", 32'(to_a), 32'h0);
    a_s_tvalid = '0;
    rst = 1'b0;
    repeat (5) tick();

    // Idle request: DRAIN for one cycle, then OFF with sinking.
    req_a = 1'b1;
    tick();
    check("idle ack in drain", 32'(ack_a), 32'h0);
    tick();
    check("idle ack", 32'(ack_a), 32'h1);
    check("idle timeout", 32'(to_a), 32'h0);
    a_s_tvalid = 2'b11; a_s_tlast = 2'b11;
    #1;
    check("idle s_tready sink", 32'(a_s_tready), 32'h3);
    check("idle m_tvalid", 32'(a_m_tvalid), 32'h0);
    a_s_tvalid = '0;
    req_a = 1'b0;
    tick();
    check("idle release ack", 32'(ack_a), 32'h0);

    // Mid-packet drain: ch0 finishes its 8-beat packet, ch1 is closed at once.
    for (int i = 1; i <= 3; i++) drive_a(0, 32'h1000_0000 + 32'(i), 1'b0, 1'b1);
    req_a = 1'b1;
    tick();
    a_s_tvalid[1] = 1'b1; a_s_tlast[1] = 1'b1;
    #1;
    check("drain ch1 s_tready", 32'(a_s_tready[1]), 32'h0);
    check("drain ch1 m_tvalid", 32'(a_m_tvalid[1]), 32'h0);
    a_s_tvalid[1] = 1'b0;
    for (int i = 4; i <= 7; i++) drive_a(0, 32'h1000_0000 + 32'(i), 1'b0, 1'b1);
    check("drain ack before last", 32'(ack_a), 32'h0);
    drive_a(0, 32'h1000_0008, 1'b1, 1'b1);
    check("drain ack after last", 32'(ack_a), 32'h1);
    check("drain timeout", 32'(to_a), 32'h0);
    req_a = 1'b0;
    tick();
    check("drain release ack", 32'(ack_a), 32'h0);

    // Forced timeout: ch0 stuck mid-packet with m_tready low for all 16 DRAIN cycles.
    drive_a(0, 32'h2000_0011, 1'b0, 1'b1);
    drive_a(0, 32'h2000_0022, 1'b0, 1'b1);
    a_m_tready[0] = 1'b0;
    req_a = 1'b1;
    a_s_tdata[W-1:0] = 32'h2000_0033; a_s_tkeep[KW-1:0] = 4'h3; a_s_tuser[0] = 1'b1;
    a_s_tlast[0] = 1'b0; a_s_tvalid[0] = 1'b1;
    tick();
    check("to ch0 s_tready", 32'(a_s_tready[0]), 32'h0);
    check("to ch0 m_tvalid", 32'(a_m_tvalid[0]), 32'h1);
    repeat (15) tick();
    check("to ack at 15", 32'(ack_a), 32'h0);
    tick();
    check("to ack at 16", 32'(ack_a), 32'h1);
    check("to flag", 32'(to_a), 32'h1);
    check("to ch0 closed", 32'(a_m_tvalid[0]), 32'h0);
    drive_a(0, 32'h2000_0033, 1'b0, 1'b0);
    drive_a(0, 32'h2000_0044, 1'b0, 1'b0);
    req_a = 1'b0;
    tick();
    check("to release ack", 32'(ack_a), 32'h0);
    check("to flag sticky", 32'(to_a), 32'h1);
    a_m_tready[0] = 1'b1;
    a_s_tdata[W-1:0] = 32'h2000_0055; a_s_tlast[0] = 1'b1; a_s_tvalid[0] = 1'b1;
    #1;
    check("resync m_tvalid", 32'(a_m_tvalid[0]), 32'h0);
    check("resync s_tready", 32'(a_s_tready[0]), 32'h1);
    drive_a(0, 32'h2000_0055, 1'b1, 1'b0);
    drive_a(0, 32'h2000_0066, 1'b0, 1'b1);
    drive_a(0, 32'h2000_0077, 1'b1, 1'b1);

    // Abort: 3-cycle request pulse during a packet; nothing lost, ack stays low.
    drive_a(0, 32'h3000_0001, 1'b0, 1'b1);
    drive_a(0, 32'h3000_0002, 1'b0, 1'b1);
    req_a = 1'b1;
    drive_a(0, 32'h3000_0003, 1'b0, 1'b1);
    check("abort timeout cleared", 32'(to_a), 32'h0);
    check("abort ack 1", 32'(ack_a), 32'h0);
    drive_a(0, 32'h3000_0004, 1'b0, 1'b1);
    check("abort ack 2", 32'(ack_a), 32'h0);
    drive_a(0, 32'h3000_0005, 1'b0, 1'b1);
    check("abort ack 3", 32'(ack_a), 32'h0);
    req_a = 1'b0;
    drive_a(0, 32'h3000_0006, 1'b0, 1'b1);
    drive_a(0, 32'h3000_0007, 1'b0, 1'b1);
    drive_a(0, 32'h3000_0008, 1'b1, 1'b1);
    check("abort ack end", 32'(ack_a), 32'h0);
    drive_a(1, 32'h3100_00F1, 1'b1, 1'b1);

    // Reset while draining a partial packet.
    drive_a(0, 32'h4000_0001, 1'b0, 1'b1);
    req_a = 1'b1;
    tick();
    rst = 1'b1;
    a_s_tlast = 2'b00; a_s_tvalid = 2'b11;
    tick();
    check("rstdrain ack", 32'(ack_a), 32'h0);
    check("rstdrain timeout", 32'(to_a), 32'h0);
    check("rstdrain m_tvalid", 32'(a_m_tvalid), 32'h0);
    check("rstdrain s_tready", 32'(a_s_tready), 32'h0);
    rst = 1'b0; a_s_tvalid = '0; req_a = 1'b0;
    tick();
    drive_a(0, 32'h4000_00A2, 1'b1, 1'b1);
    drive_a(1, 32'h4100_00B3, 1'b1, 1'b1);

    // Hold mode: S side stalls while OFF, beats delivered unchanged after release.
    req_b = 1'b1;
    tick(); tick();
    check("hold ack", 32'(ack_b), 32'h1);
    b_s_tdata = {32'h5100_00C5, 32'h5000_00D4};
    b_s_tkeep = {4'hC, 4'hD};
    b_s_tuser = 2'b10;
    b_s_tlast = 2'b11;
    b_s_tvalid = 2'b11;
    exp_q[2].push_back(mk(32'h5000_00D4, 1'b1));
    exp_q[3].push_back(mk(32'h5100_00C5, 1'b1));
    #1;
    check("hold s_tready", 32'(b_s_tready), 32'h0);
    check("hold m_tvalid", 32'(b_m_tvalid), 32'h0);
    repeat (3) tick();
    check("hold s_tready later", 32'(b_s_tready), 32'h0);
    req_b = 1'b0;
    tick();
    check("hold release ack", 32'(ack_b), 32'h0);
    check("hold release s_tready", 32'(b_s_tready), 32'h3);
    tick();
    b_s_tvalid = '0;
    check("hold timeout", 32'(to_b), 32'h0);

    repeat (3) tick();
    for (int q = 0; q < 4; q++) check("queue drained", 32'(exp_q[q].size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
